// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the req/gnt/rvalid data bus, holds the
// pipeline while an access is outstanding, and extends load data for WB.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushM,
    input  logic        mem_read_MEM,
    input  logic        mem_write_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] result_MEM,
    input  logic [31:0] rs2_MEM,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_gnt,
    input  logic        d_rvalid,
    input  logic [31:0] d_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall_req,
    output logic        access_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

    state_t      r_state, w_next;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;

    logic        w_access, w_store, w_err, w_valid, w_latch, w_capture;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_access   = (mem_read_MEM | mem_write_MEM) & ~flushM;
    assign w_store    = mem_write_MEM;
    assign access_err = w_access & w_err;
    assign w_valid    = w_access & ~w_err;

    always_comb begin
        w_err = 1'b0;
        case (funct3_MEM)
            3'b000, 3'b100: w_err = 1'b0;
            3'b001, 3'b101: w_err = result_MEM[0];
            3'b010:         w_err = (result_MEM[1:0] != 2'b00);
            default:        w_err = 1'b1;
        endcase
        // unsigned widths only exist for loads
        if (funct3_MEM[2] && w_store)
            w_err = 1'b1;
    end

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = rs2_MEM;
        case (funct3_MEM[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << result_MEM[1:0];
                w_wdata = {4{rs2_MEM[7:0]}};
            end
            2'b01: begin
                w_strb  = result_MEM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2_MEM[15:0]}};
            end
            default: ;
        endcase
        if (!w_store)
            w_strb = 4'b0000;
    end

    always_comb begin
        w_byte = d_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = d_rdata[15:8];
            2'd2:    w_byte = d_rdata[23:16];
            2'd3:    w_byte = d_rdata[31:24];
            default: w_byte = d_rdata[7:0];
        endcase
        w_half = r_off[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = d_rdata;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        stall_req = 1'b0;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    d_req   = 1'b1;
                    d_we    = w_store;
                    d_addr  = {result_MEM[31:2], 2'b00};
                    d_wdata = w_wdata;
                    d_wstrb = w_strb;
                    w_latch = 1'b1;
                    if (d_gnt) begin
                        if (!w_store) begin
                            w_next    = S_RESP;
                            stall_req = 1'b1;
                        end
                    end else begin
                        w_next    = S_REQ;
                        stall_req = 1'b1;
                    end
                end
            end
            S_REQ: begin
                d_req     = ~flushM;
                d_we      = r_we;
                d_addr    = r_addr;
                d_wdata   = r_wdata;
                d_wstrb   = r_wstrb;
                stall_req = ~(r_we & d_gnt & ~flushM);
                if (flushM)
                    w_next = S_IDLE;
                else if (d_gnt)
                    w_next = r_we ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                stall_req = ~d_rvalid;
                if (d_rvalid) begin
                    w_capture = ~flushM;
                    w_next    = S_IDLE;
                end else if (flushM) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                stall_req = w_access;
                if (d_rvalid)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            load_data  <= '0;
            load_valid <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_f3       <= '0;
            r_off      <= '0;
        end else begin
            r_state    <= w_next;
            load_valid <= w_capture;
            if (w_capture)
                load_data <= w_ext;
            if (w_latch) begin
                r_we    <= w_store;
                r_addr  <= {result_MEM[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_wstrb <= w_strb;
                r_f3    <= funct3_MEM;
                r_off   <= result_MEM[1:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushM;
    logic        mem_read_MEM;
    logic        mem_write_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] result_MEM;
    logic [31:0] rs2_MEM;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall_req;
    logic        access_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_load = '0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .flushM       (flushM),
        .mem_read_MEM (mem_read_MEM),
        .mem_write_MEM(mem_write_MEM),
        .funct3_MEM   (funct3_MEM),
        .result_MEM   (result_MEM),
        .rs2_MEM      (rs2_MEM),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wstrb      (d_wstrb),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .stall_req    (stall_req),
        .access_err   (access_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flushM        = 1'b0;
        mem_read_MEM  = 1'b0;
        mem_write_MEM = 1'b0;
        d_gnt         = 1'b0;
        d_rvalid      = 1'b0;
    endtask

    // Reference model: access size in bytes is 1, 2 or 4.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int n = size_of(f3);
        if (int'(f3) % 4 == 3) return 1'b1;
        if (int'(f3) >= 6) return 1'b1;
        if (we && int'(f3) >= 4) return 1'b1;
        if (int'(a % 32'(n)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int n = size_of(f3);
        int s = ((1 << n) - 1) << int'(a % 4);
        return 32'(s & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int     n    = size_of(f3);
        longint mask = (64'd1 << (8 * n)) - 1;
        longint rep  = (n == 1) ? 64'h01010101 : (n == 2) ? 64'h00010001 : 64'd1;
        longint v    = (longint'(wd) & mask) * rep;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int     n    = size_of(f3);
        longint full = 64'd1 << (8 * n);
        longint v    = (longint'(rd) >> (8 * int'(a % 4))) & (full - 1);
        if (int'(f3) < 4 && n < 4 && v >= full / 2)
            v = v - full;
        return v[31:0];
    endfunction

    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int gdly, input int rdly,
                             input logic [31:0] rd);
        logic [31:0] t;
        mem_read_MEM  = !we;
        mem_write_MEM = we;
        funct3_MEM    = f3;
        result_MEM    = a;
        rs2_MEM       = wd;
        flushM        = 1'b0;
        d_rvalid      = 1'b0;
        if (model_err(we, f3, a)) begin
            d_gnt = 1'($urandom_range(0, 1));
            #3;
            check("err_flag", 32'(access_err), 32'd1);
            check("err_req", 32'(d_req), 32'd0);
            check("err_stall", 32'(stall_req), 32'd0);
            step();
            idle_inputs();
            return;
        end
        for (int c = 0; c <= gdly; c++) begin
            d_gnt = (c == gdly);
            if (c > 0) begin
                t          = $urandom();
                result_MEM = {t[31:2], a[1:0]};
                rs2_MEM    = $urandom();
            end
            #3;
            check("req", 32'(d_req), 32'd1);
            check("we", 32'(d_we), 32'(we));
            check("addr", d_addr, a & 32'hFFFF_FFFC);
            check("strb", 32'(d_wstrb), we ? model_strb(f3, a) : 32'd0);
            if (we) check("wdata", d_wdata, model_wdata(f3, wd));
            check("no_err", 32'(access_err), 32'd0);
            check("req_stall", 32'(stall_req), 32'(!(we && c == gdly)));
            step();
        end
        d_gnt = 1'b0;
        if (!we) begin
            for (int r = 1; r <= rdly; r++) begin
                d_rvalid = (r == rdly);
                d_rdata  = (r == rdly) ? rd : $urandom();
                #3;
                check("resp_req", 32'(d_req), 32'd0);
                check("resp_stall", 32'(stall_req), 32'(r != rdly));
                check("resp_lv", 32'(load_valid), 32'd0);
                step();
            end
            idle_inputs();
            last_load = model_load(f3, a, rd);
            check("lv", 32'(load_valid), 32'd1);
            check("ldata", load_data, last_load);
            step();
            check("lv_pulse", 32'(load_valid), 32'd0);
            check("ldata_hold", load_data, last_load);
        end else begin
            idle_inputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, t;
        bit          we;
        int          n;

        rst        = 1'b1;
        funct3_MEM = '0;
        result_MEM = '0;
        rs2_MEM    = '0;
        d_rdata    = '0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #3;
        check("rst_ldata", load_data, 32'd0);
        check("rst_lv", 32'(load_valid), 32'd0);
        check("rst_req", 32'(d_req), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_err", 32'(access_err), 32'd0);
        step();

        do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0);
        do_access(1'b1, 3'b000, 32'h203, 32'h0000005A, 0, 0, 32'd0);
        do_access(1'b0, 3'b000, 32'h201, 32'd0, 2, 3, 32'h000080FF);
        do_access(1'b0, 3'b101, 32'h202, 32'd0, 0, 1, 32'h80010000);
        do_access(1'b0, 3'b001, 32'h202, 32'd0, 1, 2, 32'h80010000);
        do_access(1'b0, 3'b010, 32'h102, 32'd0, 0, 1, 32'd0);
        do_access(1'b1, 3'b100, 32'h100, 32'h11, 0, 0, 32'd0);

        // Flush while waiting for the response: that rvalid must be dropped.
        mem_read_MEM = 1'b1;
        funct3_MEM   = 3'b010;
        result_MEM   = 32'h300;
        d_gnt        = 1'b1;
        #3;
        check("fl_req", 32'(d_req), 32'd1);
        step();
        d_gnt  = 1'b0;
        flushM = 1'b1;
        #3;
        check("fl_resp_req", 32'(d_req), 32'd0);
        check("fl_resp_stall", 32'(stall_req), 32'd1);
        step();
        flushM     = 1'b0;
        result_MEM = 32'h304;
        d_gnt      = 1'b1;
        d_rvalid   = 1'b1;
        d_rdata    = 32'hBAD0BAD0;
        #3;
        check("drain_req", 32'(d_req), 32'd0);
        check("drain_stall", 32'(stall_req), 32'd1);
        step();
        idle_inputs();
        check("drain_lv", 32'(load_valid), 32'd0);
        check("drain_ldata", load_data, last_load);
        do_access(1'b0, 3'b010, 32'h304, 32'd0, 0, 1, 32'h12345678);

        // Reset during RESP abandons the outstanding response.
        mem_read_MEM = 1'b1;
        funct3_MEM   = 3'b010;
        result_MEM   = 32'h400;
        d_gnt        = 1'b1;
        step();
        d_gnt = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        last_load = '0;
        idle_inputs();
        d_rvalid = 1'b1;
        d_rdata  = 32'hCAFEF00D;
        #3;
        check("rstr_req", 32'(d_req), 32'd0);
        check("rstr_stall", 32'(stall_req), 32'd0);
        step();
        d_rvalid = 1'b0;
        check("rstr_lv", 32'(load_valid), 32'd0);
        check("rstr_ldata", load_data, last_load);

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                n  = $urandom_range(0, 4);
                f3 = 3'((n < 3) ? n : n + 1);
            end
            t = $urandom();
            n = size_of(f3);
            a = ($urandom_range(0, 4) == 0) ? t : (t & ~32'(n - 1));
            do_access(we, f3, a, $urandom(), $urandom_range(0, 2), $urandom_range(1, 3),
                      $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
